branch_hist_table: RTL

BRANCH_HIST_TABLE -- requirements
Module: branch_hist_table

---
 rtl/branch_hist_table.sv | 106 ++++++++++
 1 files changed

// File: rtl/branch_hist_table.sv
// Bimodal branch history table of 2-bit saturating counters with 1-cycle registered lookup.
// Define BHT_GSHARE_EN to XOR a non-speculative global history into the lookup index.
module branch_hist_table #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             if_vld,
  input  logic [15:0]      if_pc,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_vld,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic [15:0]      stat_br,
  output logic [15:0]      stat_miss
);

  localparam logic [1:0] CTR_WNT = 2'b01;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11)
      r = c + 2'b01;
    else if (!taken && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]       ctr_q [ENTRIES];
  logic [IDX_W-1:0] lk_idx_p0;
  logic [1:0]       upd_nxt_p0;
  logic [1:0]       lk_ctr_p0;
  logic             unused_pc;

  assign unused_pc = ^if_pc[15:IDX_W];

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] hist_q;

  // History only advances on resolved branches, so lookups see the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hist_q <= '0;
    else if (upd_vld)
      hist_q <= {hist_q[IDX_W-2:0], upd_taken};
  end

  assign lk_idx_p0 = if_pc[IDX_W-1:0] ^ hist_q;
`else
  assign lk_idx_p0 = if_pc[IDX_W-1:0];
`endif

  // Stage p0: counter read with write bypass from a same-cycle update
  always_comb begin
    upd_nxt_p0 = ctr_step(ctr_q[upd_idx], upd_taken);
    lk_ctr_p0  = ctr_q[lk_idx_p0];
    if (upd_vld && (upd_idx == lk_idx_p0))
      lk_ctr_p0 = upd_nxt_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= CTR_WNT;
    end else if (upd_vld) begin
      ctr_q[upd_idx] <= upd_nxt_p0;
    end
  end

  // Stage p1: registered prediction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_vld <= if_vld;
      if (if_vld) begin
        pred_taken <= lk_ctr_p0[1] & en;
        pred_idx   <= lk_idx_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br   <= '0;
      stat_miss <= '0;
    end else if (upd_vld) begin
      stat_br <= sat_inc16(stat_br);
      if (upd_mispred)
        stat_miss <= sat_inc16(stat_miss);
    end
  end

endmodule
